// File: rtl/tree_reduce_pkg.sv
// Shared types and default widths for the sequential tree-reduction block.
package tree_reduce_pkg;

    localparam int unsigned ACC_W_DEFAULT = 32;
    localparam int unsigned LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/config_binary_tree_adder.sv
// Combinational pairwise adder tree over INPUTS_AMOUNT signed P-bit elements.
// In halved-precision mode each element is taken as two signed P/2-bit lanes.
module config_binary_tree_adder #(
    parameter int unsigned P             = 8,
    parameter int unsigned INPUTS_AMOUNT = 8,
    parameter int unsigned SUM_W         = P + $clog2(INPUTS_AMOUNT)
) (
    input  logic [INPUTS_AMOUNT*P-1:0] data,
    input  logic                       halved_precision,
    output logic signed [SUM_W-1:0]    sum
);

    localparam int unsigned HALF = P / 2;

    // Leaf values feed a log2(INPUTS_AMOUNT)-deep tree; SUM_W is wide enough that no level overflows.
    function automatic logic signed [SUM_W-1:0] reduce(
        input logic [INPUTS_AMOUNT*P-1:0] vec,
        input logic                       halved
    );
        logic signed [SUM_W-1:0] node [INPUTS_AMOUNT];
        for (int k = 0; k < int'(INPUTS_AMOUNT); k++) begin
            if (halved) begin
                node[k] = SUM_W'($signed(vec[k*P +: HALF]))
                        + SUM_W'($signed(vec[k*P+HALF +: (P-HALF)]));
            end else begin
                node[k] = SUM_W'($signed(vec[k*P +: P]));
            end
        end
        for (int n = int'(INPUTS_AMOUNT / 2); n >= 1; n = n / 2) begin
            for (int i = 0; i < n; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        return node[0];
    endfunction

    always_comb begin
        sum = reduce(data, halved_precision);
    end

endmodule

// File: rtl/tree_reduce_seq.sv
// Job-based accumulator: takes a length descriptor, sums that many tree-reduced
// input vectors, then holds the result until it is consumed.
module tree_reduce_seq
    import tree_reduce_pkg::*;
#(
    parameter int unsigned P             = 8,
    parameter int unsigned INPUTS_AMOUNT = 8,
    parameter int unsigned ACC_W         = ACC_W_DEFAULT,
    parameter int unsigned LEN_W         = LEN_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       cfg_halved,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUTS_AMOUNT*P-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_sum,
    output logic                       busy
);

    localparam int unsigned SUM_W = P + $clog2(INPUTS_AMOUNT);

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic [LEN_W-1:0]        cnt, cnt_next;
    logic [LEN_W-1:0]        len_q, len_next;
    logic                    halved_q, halved_next;
    logic                    cfg_ready_next, in_ready_next, out_valid_next, busy_next;
    logic signed [SUM_W-1:0] tree_sum;

    config_binary_tree_adder #(
        .P             (P),
        .INPUTS_AMOUNT (INPUTS_AMOUNT)
    ) u_adder (
        .data             (in_data),
        .halved_precision (halved_q),
        .sum              (tree_sum)
    );

    assign out_sum = acc;

    // Next-state, datapath and handshake-flag decode.
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        cnt_next    = cnt;
        len_next    = len_q;
        halved_next = halved_q;
        unique case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    len_next    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    halved_next = cfg_halved;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready) begin
                    acc_next = acc + ACC_W'(tree_sum);
                    cnt_next = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flags come from the next state so they are registered yet aligned with it.
        cfg_ready_next = (state_next == IDLE);
        in_ready_next  = (state_next == ACCUM);
        out_valid_next = (state_next == DONE);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= LEN_W'(1);
            halved_q  <= 1'b0;
            cfg_ready <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            len_q     <= len_next;
            halved_q  <= halved_next;
            cfg_ready <= cfg_ready_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_tree_reduce_seq.sv
// Directed bench for tree_reduce_seq: a 32-bit and an 8-bit accumulator instance
// share all stimulus; expected sums are hand-computed constants.
module tb_tree_reduce_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_halved, in_valid, out_ready;
    logic [7:0]  cfg_len;
    logic [63:0] in_data;

    logic               cfg_ready, in_ready, out_valid, busy;
    logic signed [31:0] out_sum;
    logic               cfg_ready8, in_ready8, out_valid8, busy8;
    logic signed [7:0]  out_sum8;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    tree_reduce_seq #(.P(8), .INPUTS_AMOUNT(8), .ACC_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len), .cfg_halved(cfg_halved),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
    );

    tree_reduce_seq #(.P(8), .INPUTS_AMOUNT(8), .ACC_W(8), .LEN_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready8), .cfg_len(cfg_len), .cfg_halved(cfg_halved),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) beats++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] vec(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic start_job(input logic [7:0] len, input logic halved);
        int n = 0;
        while (!cfg_ready && n < 20) begin tick(); n++; end
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_valid  = 1'b1;
        cfg_len    = len;
        cfg_halved = halved;
        tick();
        cfg_valid  = 1'b0;
        cfg_len    = 8'd5;
        cfg_halved = ~halved;
        check("busy_in_job", busy, 1);
    endtask

    task automatic send_beat(input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin tick(); n++; end
        check("in_ready_for_beat", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume(input string tag, input logic signed [31:0] exp);
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_sum, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
    endtask

    initial begin
        int b0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_len = 8'd0; cfg_halved = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        check("rst8_cfg_ready", cfg_ready8, 1);
        check("rst8_in_ready", in_ready8, 0);
        check("rst8_out_valid", out_valid8, 0);
        check("rst8_out_sum", out_sum8, 0);
        check("rst8_busy", busy8, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single beat, result the cycle after the handshake
        start_job(8'd1, 1'b0);
        send_beat(vec(1, 2, 3, 4, 5, 6, 7, 8));
        check("len1_latency", out_valid, 1);
        consume("len1_sum", 36);
        tick();

        // Three beats with idle gaps, then a stalled result
        b0 = beats;
        start_job(8'd3, 1'b0);
        send_beat(vec(1, 2, 3, 4, 5, 6, 7, 8));
        tick(); tick();
        send_beat(vec(1, -2, 3, -4, 5, -6, 7, -8));
        tick(); tick();
        send_beat(vec(127, -128, 0, 1, 0, 0, 0, 0));
        in_valid = 1'b1;
        in_data  = vec(9, 9, 9, 9, 9, 9, 9, 9);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_out_sum", out_sum, 32);
            check("stall_in_ready", in_ready, 0);
            check("stall_cfg_ready", cfg_ready, 0);
            cfg_valid = (i == 2);
            tick();
        end
        in_valid = 1'b0;
        check("len3_beats", beats - b0, 3);
        cfg_valid = 1'b1;
        cfg_len   = 8'd1;
        consume("len3_sum", 32);
        check("no_accept_on_consume", busy, 0);
        check("no_accept_in_ready", in_ready, 0);
        cfg_valid = 1'b0;
        tick();

        // Zero length behaves as one
        start_job(8'd0, 1'b0);
        send_beat(vec(-127, 5, 2, 1, -6, 1, -35, 6));
        check("len0_in_ready", in_ready, 0);
        consume("len0_sum", -153);
        tick();

        // Halved precision: 0x8F -> -8 + -1, 0x21 -> 2 + 1 per element
        start_job(8'd1, 1'b1);
        send_beat({8{8'h8F}});
        consume("halved_neg_sum", -72);
        tick();
        start_job(8'd2, 1'b1);
        send_beat({8{8'h21}});
        send_beat({8{8'h8F}});
        consume("halved_latched_sum", -48);
        tick();

        // Asynchronous reset mid-job discards the partial sum
        start_job(8'd4, 1'b0);
        send_beat(vec(1, 2, 3, 4, 5, 6, 7, 8));
        send_beat(vec(1, 2, 3, 4, 5, 6, 7, 8));
        check("midjob_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sum", out_sum, 0);
        check("async_rst_cfg_ready", cfg_ready, 1);
        check("async_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        start_job(8'd1, 1'b0);
        send_beat(vec(1, 2, 3, 4, 5, 6, 7, 8));
        consume("post_rst_sum", 36);
        tick();

        // Narrow accumulator wraps: 2032 mod 256 = 240 -> -16
        start_job(8'd2, 1'b0);
        send_beat({8{8'd127}});
        send_beat({8{8'd127}});
        check("wrap8_valid", out_valid8, 1);
        check("wrap8_busy", busy8, 1);
        check("wrap8_sum", out_sum8, -16);
        consume("wide_sum", 2032);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
